// File: rtl/fp_pkg.sv
// Shared floating-point types and special-value encoders for the multiplier result path.
package fp_pkg;

    localparam int FP_EXP_WIDTH      = 8;
    localparam int FP_MANTISSA_WIDTH = 23;

    typedef struct packed {
        logic                         sign;
        logic [FP_EXP_WIDTH-1:0]      exp;
        logic [FP_MANTISSA_WIDTH-1:0] mantissa;
    } fp_word_t;

    typedef struct packed {
        fp_word_t word;
        logic     of;
        logic     uf;
    } fp_entry_t;

    function automatic fp_word_t fp_inf(input logic sign);
        fp_word_t w;
        w.sign     = sign;
        w.exp      = '1;
        w.mantissa = '0;
        return w;
    endfunction

    function automatic fp_word_t fp_zero(input logic sign);
        fp_word_t w;
        w.sign     = sign;
        w.exp      = '0;
        w.mantissa = '0;
        return w;
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// Power-of-two circular FIFO with a combinational head read; pushes when full and pops when empty are ignored.
module fp_result_fifo
    import fp_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fp_entry_t
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output T                           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rdPtr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fp_mult_result_stage.sv
// Registered, FIFO-buffered output stage of the FP multiplier: saturates overflow to infinity, flushes underflow to zero.
// Optional sticky overflow/underflow flags are built when FP_STICKY_FLAGS_EN is defined.
module fp_mult_result_stage
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH      = FP_EXP_WIDTH,
    parameter int MANTISSA_WIDTH = FP_MANTISSA_WIDTH,
    parameter int DEPTH          = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] fpm_in,
    input  logic                              overflow_in,
    input  logic                              underflow_in,
    input  logic                              valid_in,
    output logic                              ready_out,
    output logic [EXP_WIDTH+MANTISSA_WIDTH:0] result_out,
    output logic                              overflow_out,
    output logic                              underflow_out,
    output logic                              valid_out,
    input  logic                              ready_in
`ifdef FP_STICKY_FLAGS_EN
    ,
    output logic                              sticky_of_out,
    output logic                              sticky_uf_out,
    input  logic                              clear_flags_in
`endif
);

    localparam int WORD_W = EXP_WIDTH + MANTISSA_WIDTH + 1;
    localparam int CNT_W  = $clog2(DEPTH+1);

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic              of;
        logic              uf;
    } entry_t;

    logic              w_sign;
    logic [WORD_W-1:0] w_inf;
    logic [WORD_W-1:0] w_zero;
    entry_t            w_enc;
    entry_t            r_cap;
    logic              r_capValid;
    entry_t            w_head;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_occupancy;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;

    assign w_sign = fpm_in[WORD_W-1];

    // Use the shared package encoders when widths match; otherwise build the same encodings locally.
    if (EXP_WIDTH == FP_EXP_WIDTH && MANTISSA_WIDTH == FP_MANTISSA_WIDTH) begin : g_pkgEnc
        assign w_inf  = fp_inf(w_sign);
        assign w_zero = fp_zero(w_sign);
    end else begin : g_localEnc
        assign w_inf  = {w_sign, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
        assign w_zero = {w_sign, {(WORD_W-1){1'b0}}};
    end

    always_comb begin
        w_enc.word = fpm_in;
        w_enc.of   = 1'b0;
        w_enc.uf   = 1'b0;
        if (overflow_in) begin
            w_enc.word = w_inf;
            w_enc.of   = 1'b1;
        end else if (underflow_in) begin
            w_enc.word = w_zero;
            w_enc.uf   = 1'b1;
        end
    end

    // Registered-only occupancy keeps ready_in off the ready_out path.
    assign w_occupancy = {1'b0, w_count} + (CNT_W+1)'(r_capValid);
    assign ready_out   = (w_occupancy < (CNT_W+1)'(DEPTH));
    assign w_accept    = valid_in && ready_out;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cap      <= '0;
            r_capValid <= 1'b0;
        end else begin
            r_capValid <= w_accept;
            if (w_accept) begin
                r_cap <= w_enc;
            end
        end
    end

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (r_capValid),
        .i_data  (r_cap),
        .i_pop   (ready_in),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Storage is not reset, so the head is masked to zero while the FIFO is empty.
    assign valid_out     = !w_empty;
    assign result_out    = w_empty ? '0 : w_head.word;
    assign overflow_out  = !w_empty && w_head.of;
    assign underflow_out = !w_empty && w_head.uf;

`ifdef FP_STICKY_FLAGS_EN
    logic w_pop;
    logic r_stickyOf;
    logic r_stickyUf;

    assign w_pop = !w_empty && ready_in;

    // A set event wins over a simultaneous clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stickyOf <= 1'b0;
            r_stickyUf <= 1'b0;
        end else begin
            if (w_pop && w_head.of) begin
                r_stickyOf <= 1'b1;
            end else if (clear_flags_in) begin
                r_stickyOf <= 1'b0;
            end
            if (w_pop && w_head.uf) begin
                r_stickyUf <= 1'b1;
            end else if (clear_flags_in) begin
                r_stickyUf <= 1'b0;
            end
        end
    end

    assign sticky_of_out = r_stickyOf;
    assign sticky_uf_out = r_stickyUf;
`endif

endmodule

// File: tb/tb_fp_mult_result_stage.sv
// Directed self-checking bench for fp_mult_result_stage (default DEPTH=4, 8/23 format).
// Sticky-flag checks are compiled in when FP_STICKY_FLAGS_EN is defined.
module tb_fp_mult_result_stage;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] fpm_in;
    logic        overflow_in;
    logic        underflow_in;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] result_out;
    logic        overflow_out;
    logic        underflow_out;
    logic        valid_out;
    logic        ready_in;
`ifdef FP_STICKY_FLAGS_EN
    logic        sticky_of_out;
    logic        sticky_uf_out;
    logic        clear_flags_in;
`endif

    int checkCount = 0;
    int errorCount = 0;

    fp_mult_result_stage #(
        .EXP_WIDTH      (8),
        .MANTISSA_WIDTH (23),
        .DEPTH          (4)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .fpm_in         (fpm_in),
        .overflow_in    (overflow_in),
        .underflow_in   (underflow_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .result_out     (result_out),
        .overflow_out   (overflow_out),
        .underflow_out  (underflow_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in)
`ifdef FP_STICKY_FLAGS_EN
        ,
        .sticky_of_out  (sticky_of_out),
        .sticky_uf_out  (sticky_uf_out),
        .clear_flags_in (clear_flags_in)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One-cycle transfer; callers only use it while ready_out is known high.
    task automatic applyStimulus(input logic [31:0] data, input logic of, input logic uf);
        fpm_in       = data;
        overflow_in  = of;
        underflow_in = uf;
        valid_in     = 1'b1;
        tick();
        valid_in     = 1'b0;
        overflow_in  = 1'b0;
        underflow_in = 1'b0;
        fpm_in       = '0;
    endtask

    task automatic expectHead(input string tag, input logic [31:0] word, input logic of, input logic uf);
        checkOutput({tag, "_valid"}, 32'(valid_out), 32'd1);
        checkOutput({tag, "_result"}, result_out, word);
        checkOutput({tag, "_of"}, 32'(overflow_out), 32'(of));
        checkOutput({tag, "_uf"}, 32'(underflow_out), 32'(uf));
    endtask

    initial begin
        rst_in       = 1'b1;
        fpm_in       = '0;
        overflow_in  = 1'b0;
        underflow_in = 1'b0;
        valid_in     = 1'b0;
        ready_in     = 1'b1;
`ifdef FP_STICKY_FLAGS_EN
        clear_flags_in = 1'b0;
`endif
        tick();
        tick();
        checkOutput("rst_ready", 32'(ready_out), 32'd1);
        checkOutput("rst_valid", 32'(valid_out), 32'd0);
        checkOutput("rst_result", result_out, 32'h0);
        checkOutput("rst_of", 32'(overflow_out), 32'd0);
        checkOutput("rst_uf", 32'(underflow_out), 32'd0);
`ifdef FP_STICKY_FLAGS_EN
        checkOutput("rst_sticky_of", 32'(sticky_of_out), 32'd0);
        checkOutput("rst_sticky_uf", 32'(sticky_uf_out), 32'd0);
`endif
        rst_in = 1'b0;
        tick();

        // Normal result: not visible right after acceptance, visible one edge later, then popped.
        applyStimulus(32'h40400000, 1'b0, 1'b0);
        checkOutput("norm_latency", 32'(valid_out), 32'd0);
        tick();
        expectHead("norm", 32'h40400000, 1'b0, 1'b0);
        tick();
        checkOutput("norm_popped", 32'(valid_out), 32'd0);

        applyStimulus(32'hC1234567, 1'b1, 1'b0);
        tick();
        expectHead("ovf", 32'hFF800000, 1'b1, 1'b0);
        tick();

        applyStimulus(32'h80012345, 1'b0, 1'b1);
        tick();
        expectHead("udf", 32'h80000000, 1'b0, 1'b1);
        tick();

        applyStimulus(32'h00012345, 1'b1, 1'b1);
        tick();
        expectHead("both", 32'h7F800000, 1'b1, 1'b0);
        tick();

        // Back-to-back stream with consumer ready: one result per cycle.
        valid_in = 1'b1;
        fpm_in   = 32'h3F800000;
        tick();
        fpm_in   = 32'h40000000;
        tick();
        checkOutput("tput_a", result_out, 32'h3F800000);
        fpm_in   = 32'h40800000;
        tick();
        checkOutput("tput_b", result_out, 32'h40000000);
        valid_in = 1'b0;
        fpm_in   = '0;
        tick();
        checkOutput("tput_c", result_out, 32'h40800000);
        tick();
        checkOutput("tput_drained", 32'(valid_out), 32'd0);

        // Backpressure: fill all four slots with the consumer stalled.
        ready_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("bp_ready_%0d", i), 32'(ready_out), 32'd1);
            fpm_in   = 32'(i);
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        fpm_in   = '0;
        checkOutput("bp_full_a", 32'(ready_out), 32'd0);
        tick();
        checkOutput("bp_full_b", 32'(ready_out), 32'd0);
        expectHead("bp_hold_a", 32'd1, 1'b0, 1'b0);
        tick();
        checkOutput("bp_hold_b", result_out, 32'd1);
        ready_in = 1'b1;
        #1;
        checkOutput("bp_no_comb", 32'(ready_out), 32'd0);
        for (int j = 1; j <= 4; j++) begin
            checkOutput($sformatf("bp_pop_valid_%0d", j), 32'(valid_out), 32'd1);
            checkOutput($sformatf("bp_pop_%0d", j), result_out, 32'(j));
            tick();
        end
        checkOutput("bp_drained", 32'(valid_out), 32'd0);
        checkOutput("bp_ready_again", 32'(ready_out), 32'd1);

        // Reset mid-stream discards buffered entries.
        ready_in = 1'b0;
        valid_in = 1'b1;
        fpm_in   = 32'h11;
        tick();
        fpm_in   = 32'h22;
        tick();
        fpm_in   = 32'h33;
        tick();
        valid_in = 1'b0;
        fpm_in   = '0;
        tick();
        checkOutput("mid_buffered", 32'(valid_out), 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        checkOutput("mid_rst_valid", 32'(valid_out), 32'd0);
        checkOutput("mid_rst_ready", 32'(ready_out), 32'd1);
        checkOutput("mid_rst_result", result_out, 32'h0);
        ready_in = 1'b1;
        applyStimulus(32'h3F800000, 1'b0, 1'b0);
        tick();
        expectHead("mid_first", 32'h3F800000, 1'b0, 1'b0);
        tick();
        checkOutput("mid_drained", 32'(valid_out), 32'd0);

`ifdef FP_STICKY_FLAGS_EN
        applyStimulus(32'h40000000, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("sticky_of_set", 32'(sticky_of_out), 32'd1);
        checkOutput("sticky_uf_clear", 32'(sticky_uf_out), 32'd0);
        applyStimulus(32'h40400000, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("sticky_of_hold", 32'(sticky_of_out), 32'd1);
        clear_flags_in = 1'b1;
        tick();
        clear_flags_in = 1'b0;
        checkOutput("sticky_of_cleared", 32'(sticky_of_out), 32'd0);
        applyStimulus(32'h80012345, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("sticky_uf_set", 32'(sticky_uf_out), 32'd1);
        checkOutput("sticky_of_stays_clear", 32'(sticky_of_out), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fp_mult_result_stage.md
Name: fp_mult_result_stage

Overview:
- Registered output stage directly downstream of the combinational floating-point multiplier.
- Captures the packed result and its overflow/underflow flags under a valid/ready handshake.
- Applies IEEE-style special-value encoding: overflow saturates to ±infinity, underflow flushes to ±zero.
- Buffers results in a small FIFO so a stalled consumer never drops a product.

Parameters:
- EXP_WIDTH, 8, exponent field width of the packed word.
- MANTISSA_WIDTH, 23, fraction field width (hidden bit not stored).
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  synchronous, active-high reset.
- fpm_in  input  EXP_WIDTH+MANTISSA_WIDTH+1  packed multiplier result {sign, exp, mantissa}.
- overflow_in  input  1  multiplier overflow flag.
- underflow_in  input  1  multiplier underflow flag.
- valid_in  input  1  fpm_in and the flags are valid.
- ready_out  output  1  stage can accept; a transfer occurs when valid_in && ready_out.
- result_out  output  EXP_WIDTH+MANTISSA_WIDTH+1  encoded result at FIFO head.
- overflow_out  output  1  head entry was saturated to infinity.
- underflow_out  output  1  head entry was flushed to zero.
- valid_out  output  1  FIFO non-empty.
- ready_in  input  1  consumer accepts; a pop occurs when valid_out && ready_in.
- sticky_of_out  output  1  sticky overflow (optional feature only).
- sticky_uf_out  output  1  sticky underflow (optional feature only).
- clear_flags_in  input  1  clears the sticky flags (optional feature only).

Behaviour:
- Reset (rst_in high at an edge):
  - FIFO pointers and count are cleared; the capture register is invalidated; sticky flags are cleared.
  - ready_out=1, valid_out=0, result_out=0, overflow_out=0, underflow_out=0.
  - Reset mid-operation discards all in-flight and buffered entries.
- Stage 1 (capture register), loaded on each accepted transfer:
  - Encodes the result. sign = fpm_in MSB.
  - overflow_in=1 → {sign, all-ones exp, zero mantissa}, flag O set. Overflow has priority when both flags are 1.
  - else underflow_in=1 → {sign, zero exp, zero mantissa}, flag U set.
  - else fpm_in passes unchanged.
- Stage 2 (FIFO): a valid capture register is written to the FIFO on the next edge.
- Latency: a transfer accepted at edge N appears at result_out with valid_out=1 after edge N+1, when the FIFO is empty. Throughput is one result per cycle.
- ready_out = (count + capture_valid) < DEPTH, computed from registers only; there is no combinational path from ready_in.
  - Full boundary: with count=DEPTH-1 and capture_valid=1, ready_out=0.
  - A simultaneous pop does not raise ready_out until the next cycle (conservative by one cycle).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pop on empty is ignored. Pointers wrap modulo DEPTH.
- The FIFO head is a combinational read of storage at the read pointer. Entries are held stable while valid_out && !ready_in.

Optional Feature:
- Macro: FP_STICKY_FLAGS_EN.
- When defined:
  - sticky_of_out/sticky_uf_out set when an entry carrying O/U is popped.
  - They hold until clear_flags_in or reset.
  - clear_flags_in and a set event in the same cycle leave the flag set.
- When undefined: the three ports are absent and no sticky logic is built.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_WIDTH and MANTISSA_WIDTH defaults.
  - A packed struct fp_word_t {sign, exp, mantissa}.
  - A function fp_inf(sign) returning the infinity encoding and a function fp_zero(sign) returning the signed-zero encoding.
  - The entry struct fp_entry_t {fp_word_t word, of, uf}.
- One sub-module, fp_result_fifo: parameterised by DEPTH and entry type, providing push/pop, count and full/empty.

Test Plan:
- Normal result: fpm_in=0x40400000, valid_in=1 for one cycle, ready_in=1 → result_out=0x40400000 with valid_out=1 exactly 1 cycle after acceptance, both flags 0.
- Overflow: fpm_in=0xC1234567, overflow_in=1 → result_out=0xFF800000, overflow_out=1.
- Underflow: fpm_in=0x80012345, underflow_in=1 → 0x80000000, underflow_out=1. With both flags set, 0x00012345 → 0x7F800000.
- Backpressure: DEPTH=4, ready_in=0, stream 1,2,3,4 → ready_out=0 after the 4th acceptance. Release ready_in → pops 1,2,3,4 in order, nothing lost or duplicated.
- Reset mid-stream: 3 entries buffered, rst_in pulsed → next cycle valid_out=0, ready_out=1. A new input 0x3F800000 is the first output.
- FP_STICKY_FLAGS_EN: pop an overflow entry → sticky_of_out=1 persists through later normal results. clear_flags_in → 0.
